// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - ChaCha constants, FSM state encodings and quarter-round helpers
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_ROUND   = 3'd2;
  localparam logic [2:0] ST_ADD     = 3'd3;
  localparam logic [2:0] ST_WAIT_IN = 3'd4;
  localparam logic [2:0] ST_OUT     = 3'd5;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Returns {a, b, c, d} after one ChaCha quarter round.
  function automatic logic [127:0] chacha_qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                             input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b; d = rotl32(d ^ a, 16);
    c = c + d; b = rotl32(b ^ c, 12);
    a = a + b; d = rotl32(d ^ a, 8);
    c = c + d; b = rotl32(b ^ c, 7);
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/chacha_stream_core_double_round.sv
// rtl/chacha_stream_core_double_round.sv - combinational ChaCha double round (columns, then diagonals)
module chacha_double_round
  import chacha_pkg::*;
(
  input  logic [511:0] state_in,
  output logic [511:0] state_out
);

  logic [31:0] w [16];
  logic [31:0] c [16];
  logic [31:0] d [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w[i] = state_in[32*(16-i)-1 -: 32];
    end
    {c[0], c[4], c[8],  c[12]} = chacha_qr(w[0], w[4], w[8],  w[12]);
    {c[1], c[5], c[9],  c[13]} = chacha_qr(w[1], w[5], w[9],  w[13]);
    {c[2], c[6], c[10], c[14]} = chacha_qr(w[2], w[6], w[10], w[14]);
    {c[3], c[7], c[11], c[15]} = chacha_qr(w[3], w[7], w[11], w[15]);
    {d[0], d[5], d[10], d[15]} = chacha_qr(c[0], c[5], c[10], c[15]);
    {d[1], d[6], d[11], d[12]} = chacha_qr(c[1], c[6], c[11], c[12]);
    {d[2], d[7], d[8],  d[13]} = chacha_qr(c[2], c[7], c[8],  c[13]);
    {d[3], d[4], d[9],  d[14]} = chacha_qr(c[3], c[4], c[9],  c[14]);
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      state_out[32*(16-i)-1 -: 32] = d[i];
    end
  end

endmodule

// File: rtl/chacha_stream_core.sv
// rtl/chacha_stream_core.sv - multi-block ChaCha keystream engine with in-line data XOR
module chacha_stream_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS       = 20,
  parameter int DR_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  input  logic [15:0]  num_blocks,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [511:0] din_data,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [511:0] dout_data
);

  localparam int R_CYCLES = ROUNDS / (2 * DR_PER_CYCLE);
  localparam logic [3:0] RND_LAST = 4'(R_CYCLES - 1);

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_stream_core: ROUNDS must be 8, 12 or 20");
  end
  if (!(DR_PER_CYCLE == 1 || DR_PER_CYCLE == 2)) begin : g_bad_dr
    $error("chacha_stream_core: DR_PER_CYCLE must be 1 or 2");
  end

  logic [2:0]   state_q, state_d;
  logic [255:0] key_q, key_d;
  logic [95:0]  nonce_q, nonce_d;
  logic [31:0]  ctr_q, ctr_d;
  logic [15:0]  rem_q, rem_d;
  logic [511:0] s_q, s_d;
  logic [511:0] orig_q, orig_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [511:0] dout_data_q, dout_data_d;
  logic         dout_valid_q, dout_valid_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [511:0] init_state;
  logic [511:0] dr_chain [DR_PER_CYCLE+1];

  assign init_state = {SIGMA0, SIGMA1, SIGMA2, SIGMA3, key_q, ctr_q, nonce_q};
  assign dr_chain[0] = s_q;

  for (genvar g = 0; g < DR_PER_CYCLE; g++) begin : g_dr
    chacha_double_round u_dr (
      .state_in  (dr_chain[g]),
      .state_out (dr_chain[g+1])
    );
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    ctr_d        = ctr_q;
    rem_d        = rem_q;
    s_d          = s_q;
    orig_d       = orig_q;
    rnd_d        = rnd_q;
    dout_data_d  = dout_data_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key;
          nonce_d = nonce;
          ctr_d   = counter;
          rem_d   = num_blocks;
          if (num_blocks == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        s_d     = init_state;
        orig_d  = init_state;
        rnd_d   = '0;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        s_d = dr_chain[DR_PER_CYCLE];
        if (rnd_q == RND_LAST) begin
          state_d = ST_ADD;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_ADD: begin
        // The keystream overwrites the working state; it is only needed until the XOR.
        for (int i = 0; i < 16; i++) begin
          s_d[32*(16-i)-1 -: 32] = s_q[32*(16-i)-1 -: 32] + orig_q[32*(16-i)-1 -: 32];
        end
        state_d = ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        if (din_valid) begin
          dout_data_d  = din_data ^ s_q;
          dout_valid_d = 1'b1;
          state_d      = ST_OUT;
        end
      end
      ST_OUT: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          rem_d        = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (ctr_q == 32'hFFFF_FFFF) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ctr_d   = ctr_q + 32'd1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      nonce_q      <= '0;
      ctr_q        <= '0;
      rem_q        <= '0;
      s_q          <= '0;
      orig_q       <= '0;
      rnd_q        <= '0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      ctr_q        <= ctr_d;
      rem_q        <= rem_d;
      s_q          <= s_d;
      orig_q       <= orig_d;
      rnd_q        <= rnd_d;
      dout_data_q  <= dout_data_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign din_ready  = (state_q == ST_WAIT_IN);
  assign done       = done_q;
  assign err        = err_q;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;

endmodule

// File: tb/tb_chacha_stream_core.sv
// tb/tb_chacha_stream_core.sv - scoreboard bench for chacha_stream_core against a software ChaCha model
module tb_chacha_stream_core;

  localparam int TB_ROUNDS = 20;
  localparam int TB_DR     = 1;
  localparam int TB_R      = TB_ROUNDS / (2 * TB_DR);
  localparam int QI [32] = '{0, 4, 8, 12,  1, 5, 9, 13,  2, 6, 10, 14,  3, 7, 11, 15,
                             0, 5, 10, 15, 1, 6, 11, 12, 2, 7, 8, 13,   3, 4, 9, 14};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  counter = '0;
  logic [15:0]  num_blocks = '0;
  logic         busy, done, err;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [511:0] din_data = '0;
  logic         dout_valid;
  logic         dout_ready;
  logic [511:0] dout_data;

  int checks = 0;
  int errors = 0;
  int out_hs = 0;
  int ready_mode = 0;
  logic [511:0] last_dout = '0;
  logic [511:0] exp_q [$];

  chacha_stream_core #(.ROUNDS(TB_ROUNDS), .DR_PER_CYCLE(TB_DR)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .nonce      (nonce),
    .counter    (counter),
    .num_blocks (num_blocks),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data)
  );

  always #5 clk = ~clk;

  function automatic int unsigned rl(input int unsigned v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  // Reference ChaCha block: RFC-style state layout, ROUNDS rounds alternating column/diagonal.
  function automatic logic [511:0] model_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c);
    int unsigned x [16];
    int unsigned o [16];
    logic [511:0] res;
    int a, b, cc, d;
    x[0] = 32'h61707865; x[1] = 32'h3320646e; x[2] = 32'h79622d32; x[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) x[4+i] = k[255-32*i -: 32];
    x[12] = c;
    for (int i = 0; i < 3; i++) x[13+i] = n[95-32*i -: 32];
    o = x;
    for (int r = 0; r < TB_ROUNDS; r++) begin
      for (int q = 0; q < 4; q++) begin
        a = QI[(r%2)*16 + q*4]; b = QI[(r%2)*16 + q*4 + 1];
        cc = QI[(r%2)*16 + q*4 + 2]; d = QI[(r%2)*16 + q*4 + 3];
        x[a] += x[b]; x[d] = rl(x[d] ^ x[a], 16);
        x[cc] += x[d]; x[b] = rl(x[b] ^ x[cc], 12);
        x[a] += x[b]; x[d] = rl(x[d] ^ x[a], 8);
        x[cc] += x[d]; x[b] = rl(x[b] ^ x[cc], 7);
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[511-32*i -: 32] = x[i] + o[i];
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [511:0] got, input logic [511:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_done"}, int'(done), 0);
    check_int({tag, "_err"}, int'(err), 0);
    check_int({tag, "_din_ready"}, int'(din_ready), 0);
    check_int({tag, "_dout_valid"}, int'(dout_valid), 0);
    check_vec({tag, "_dout_data"}, dout_data, '0);
  endtask

  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: dout_ready = 1'b1;
        1: dout_ready = ($urandom % 3) != 0;
        default: dout_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: pops one expectation per dout handshake and checks stability under stall.
  initial begin
    logic [511:0] prev;
    logic [511:0] e;
    bit stall;
    stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
      end else if (dout_valid) begin
        if (stall) check_vec("dout_stable", dout_data, prev);
        if (dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dout got %h required no output", dout_data);
          end else begin
            e = exp_q.pop_front();
            check_vec("dout_data", dout_data, e);
          end
          out_hs++;
          last_dout = dout_data;
          stall = 0;
        end else begin
          stall = 1;
        end
        prev = dout_data;
      end else begin
        stall = 0;
      end
    end
  end

  task automatic run_job(input logic [255:0] k, input logic [95:0] nn, input logic [31:0] c,
                         input logic [15:0] nb, input bit rnd_din, input bit zero_din);
    longint avail;
    int exp_blocks, n, blk, hs0, busy_start;
    bit exp_err, seen_rdy, seen_dv, fin;
    logic [511:0] g;
    avail = 64'h1_0000_0000 - {32'b0, c};
    exp_err = longint'(nb) > avail;
    exp_blocks = exp_err ? int'(avail) : int'(nb);
    hs0 = out_hs;
    busy_start = $urandom_range(1, TB_R - 1);
    n = 0; blk = 0; seen_rdy = 0; seen_dv = 0; fin = 0;
    @(posedge clk); #1;
    start = 1; key = k; nonce = nn; counter = c; num_blocks = nb; din_valid = 0;
    @(posedge clk); #1;
    start = 0;
    g = rand512();
    key = g[255:0]; nonce = g[351:256]; counter = g[383:352]; num_blocks = g[399:384];
    din_valid = rnd_din ? 1'($urandom % 2) : 1'b1;
    din_data = zero_din ? '0 : rand512();
    while (!fin && n < 3000) begin
      @(negedge clk);
      n++;
      if (din_ready && !seen_rdy) begin
        seen_rdy = 1;
        check_int("start_to_din_ready", n, TB_R + 3);
      end
      if (dout_valid && !seen_dv && !rnd_din) begin
        seen_dv = 1;
        check_int("din_to_dout_valid", n, TB_R + 4);
      end
      if (din_valid && din_ready) begin
        exp_q.push_back(din_data ^ model_block(k, nn, c + 32'(blk)));
        blk++;
      end
      if (done) begin
        fin = 1;
        check_int("done_err", int'(err), int'(exp_err));
        check_int("done_busy", int'(busy), 0);
      end else begin
        @(posedge clk); #1;
        start = (nb != 0) && (n == busy_start);
        din_valid = rnd_din ? 1'($urandom % 2) : 1'b1;
        din_data = zero_din ? '0 : rand512();
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL job_timeout got no done required done within 3000 cycles");
    end
    if (nb == 0) check_int("zero_blocks_done_latency", n, 1);
    check_int("din_handshakes", blk, exp_blocks);
    check_int("dout_handshakes", out_hs - hs0, exp_blocks);
    check_int("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    start = 0; din_valid = 0;
    @(negedge clk);
    check_int("done_pulse_width", int'(done), 0);
  endtask

  task automatic reset_mid(input bit in_out);
    int n;
    logic [511:0] g;
    g = rand512();
    ready_mode = 2;
    n = 0;
    @(posedge clk); #1;
    start = 1; key = g[255:0]; nonce = g[351:256]; counter = 32'd5; num_blocks = 16'd2;
    @(posedge clk); #1;
    start = 0; din_valid = 1; din_data = rand512();
    do begin
      @(negedge clk);
      n++;
    end while (n < 200 && (in_out ? !dout_valid : n < 4));
    check_int(in_out ? "reached_out" : "reached_round", int'(in_out ? dout_valid : busy), 1);
    #2 rst = 1;
    #1 check_quiet(in_out ? "rst_in_out" : "rst_in_round");
    @(posedge clk); #1;
    rst = 0; din_valid = 0; ready_mode = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_int("post_reset_no_done", int'(done), 0);
  endtask

  initial begin
    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    logic [511:0] g;
    logic [31:0]  c;
    rfc_key = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
               32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
    rfc_nonce = {32'h09000000, 32'h4a000000, 32'h00000000};

    repeat (3) @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rst = 0;

    run_job(rfc_key, rfc_nonce, 32'd1, 16'd1, 0, 1);
    check_int("rfc_word0", int'(last_dout[511:480]), int'(32'he4e7f110));
    check_int("rfc_word15", int'(last_dout[31:0]), int'(32'h4e3c50a2));

    ready_mode = 1;
    run_job(rfc_key, rfc_nonce, 32'd1, 16'd3, 0, 1);

    for (int j = 0; j < 6; j++) begin
      g = rand512();
      ready_mode = $urandom % 2;
      c = ($urandom % 3 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
      run_job(g[255:0], g[351:256], c, 16'($urandom_range(1, 4)), 1, 0);
    end

    ready_mode = 0;
    run_job(rand512()[255:0] ^ 256'h0, rfc_nonce, 32'hFFFF_FFFF, 16'd2, 0, 0);
    ready_mode = 1;
    run_job(rfc_key, rfc_nonce, 32'hFFFF_FFFE, 16'd3, 1, 0);
    ready_mode = 0;
    run_job(rfc_key, rfc_nonce, 32'd7, 16'd0, 0, 0);

    reset_mid(0);
    run_job(rfc_key, rfc_nonce, 32'd1, 16'd1, 0, 1);
    check_int("after_rst_word0", int'(last_dout[511:480]), int'(32'he4e7f110));
    reset_mid(1);
    g = rand512();
    run_job(g[255:0], g[351:256], g[383:352], 16'd2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chacha_stream_core.md
# chacha_stream_core

Parametrised ChaCha block-function engine with integrated keystream XOR and multi-block streaming. It replaces the single-block ChaCha20 core in the crypto datapath. One job covers `num_blocks` consecutive blocks with an auto-incremented counter; 512-bit data blocks enter and leave over valid/ready handshakes. Round count (ChaCha8/12/20) and double-rounds per cycle are compile-time choices.

## Interface
- `ROUNDS`, default 20: total rounds. Legal values are 8, 12, 20; any other value is an elaboration error.
- `DR_PER_CYCLE`, default 1: double-rounds evaluated per clock. Legal values are 1 and 2.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: job request, sampled only in IDLE.
- `key` in 256: key words 0..7; word 0 is in `[255:224]`.
- `nonce` in 96: nonce words 0..2; word 0 is in `[95:64]`.
- `counter` in 32: initial block counter.
- `num_blocks` in 16: blocks in the job.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job end.
- `err` out 1: one-cycle pulse together with `done` when the job ends on counter overflow.
- `din_valid` in 1, `din_ready` out 1, `din_data` in 512: input data handshake.
- `dout_valid` out 1, `dout_ready` in 1, `dout_data` out 512: output data handshake.

## Operation
- **Word order.** State word i sits at bits `[32*(16-i)-1 -: 32]` of every 512-bit bus. Word 0 is in the MSBs. Words are already little-endian-interpreted; byte swapping is host-side.
- **Initial state.** Words 0..3 are the SIGMA constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Words 4..11 are the key, word 12 is the counter, and words 13..15 are the nonce.
- **Input capture.** `key`, `nonce`, `counter` and `num_blocks` are captured on start acceptance. Later changes to these inputs are ignored until the next start.
- **State machine.**
  - IDLE: if `start`, capture the inputs. If `num_blocks` == 0, pulse `done` and stay in IDLE. Otherwise go to LOAD.
  - LOAD: build the state from the captured values and the current block counter. Copy it to `orig`. Go to ROUND.
  - ROUND: apply DR_PER_CYCLE double-rounds (column then diagonal) per cycle for R = ROUNDS/(2*DR_PER_CYCLE) cycles. Go to ADD.
  - ADD: `ks[i] = s[i] + orig[i]` mod 2^32. Go to WAIT_IN.
  - WAIT_IN: `din_ready` = 1. On `din_valid`, register `dout_data = din_data ^ ks` and set `dout_valid`. Go to OUT.
  - OUT: hold `dout_valid` and `dout_data` stable until `dout_ready`. Then decrement the remaining-block count.
    - If blocks remain and counter ≠ 0xFFFFFFFF: increment the counter and go to LOAD.
    - If blocks remain and counter == 0xFFFFFFFF: pulse `done` and `err`, go to IDLE. The counter never wraps.
    - If no blocks remain: pulse `done`, go to IDLE.
- **busy and start.** `busy` = (state ≠ IDLE). `start` while busy is ignored.
- **Mode.** Encryption and decryption are the same operation, so there is no mode input.

## Timing
- **Reset values.** `busy`, `done`, `err`, `din_ready`, `dout_valid` are 0 and `dout_data` is 0. State is IDLE and all internal registers are 0.
- **Reset mid-job.** Reset aborts the job immediately. No `done` is produced and no partial output appears.
- **Start to din_ready.** With `start` accepted at edge T, `din_ready` is first high in the cycle after edge T+R+2. R = 10 for ChaCha20 with DR_PER_CYCLE = 1.
- **din to dout.** `dout_valid` rises at the edge after the `din` handshake, i.e. 1-cycle latency.
- **Per-block cost.** Each block takes R+4 cycles when there is no backpressure. Blocks are not overlapped.
- **Stall behaviour.** `din_ready` is combinational from state only. Stalls are unbounded on either side.
- **done/err timing.** `done` and `err` are asserted in the cycle after the final `dout` handshake, alongside `busy` = 0.

## Structure
- **Package `chacha_pkg`:**
  - SIGMA word constants.
  - State enum: IDLE, LOAD, ROUND, ADD, WAIT_IN, OUT.
  - 32-bit rotate-left function.
  - Quarter-round function returning 4×32 bits.
- **Sub-module `chacha_double_round`:** combinational, 512 bits in to 512 bits out, with 4 column QRs then 4 diagonal QRs on the column outputs. The core instantiates DR_PER_CYCLE copies chained in series.

## Test plan
- **RFC 8439 §2.3.2 vector.** Stimulus: key 0x00010203..1c1d1e1f as LE words, nonce 000000090000004a00000000, counter 1, num_blocks 1, din 0. Required: `dout` word0 = 0xe4e7f110, word15 = 0x4e3c50a2, `dout_valid` after edge T+13, then `done`.
- **Multi-block with backpressure.** Stimulus: num_blocks 3, counter 1, random `dout_ready` stalls, din = 0. Required: block 2 matches the RFC block with counter 2; `dout_data` is stable while stalled; exactly 3 `dout` handshakes.
- **Round variants.** Stimulus: ROUNDS 8/12/20 × DR_PER_CYCLE 1/2. Required: results match the software model; start-to-`din_ready` latency equals R+2.
- **Counter overflow.** Stimulus: counter 0xFFFFFFFF, num_blocks 2. Required: one block output, then `done` = `err` = 1 in the same cycle, and no second block.
- **Boundaries.** num_blocks 0 gives `done` one cycle after `start`, with no `busy` and no output. `start` while busy is ignored.
- **Reset mid-job.** Assert `rst` during ROUND and during OUT. Required: all outputs are 0 immediately, and a fresh job afterwards produces correct data.
